// File: rtl/systolic_pe.sv
// Output-stationary systolic MAC cell: pops paired west/north operands, forwards them
// east/south, and accumulates their signed products through a two-stage pipeline.
module systolic_pe #(
    parameter int DW = 16,
    parameter int AW = 40,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] mac_num,
    input  logic          is,
    input  logic          a_rv,
    input  logic          b_rv,
    input  logic [DW-1:0] a_din,
    input  logic [DW-1:0] b_din,
    output logic          a_re,
    output logic          b_re,
    input  logic          a_ff,
    input  logic          b_ff,
    output logic          a_we,
    output logic          b_we,
    output logic [DW-1:0] a_dout,
    output logic [DW-1:0] b_dout,
    output logic          busy,
    output logic          acc_vld,
    input  logic          acc_rdy,
    output logic [AW-1:0] acc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          rem_q, rem_d;
    logic [AW-1:0]          acc_q, acc_d;
    logic signed [2*DW-1:0] prod_q, prod_d;
    logic                   prod_vld_q, prod_vld_d;
    logic                   fwd_vld_q, fwd_vld_d;
    logic [DW-1:0]          a_dout_q, a_dout_d;
    logic [DW-1:0]          b_dout_q, b_dout_d;
    logic                   fire;

    // Both operands move together or not at all; reset blocks any pop in its cycle.
    assign fire = ~rst && (state_q == RUN) && a_rv && b_rv && ~a_ff && ~b_ff && ~is
                  && (rem_q != '0);

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        acc_d      = acc_q;
        prod_d     = prod_q;
        a_dout_d   = a_dout_q;
        b_dout_d   = b_dout_q;
        prod_vld_d = fire;
        fwd_vld_d  = fire;

        if (fire) begin
            prod_d   = (2*DW)'($signed(a_din)) * (2*DW)'($signed(b_din));
            a_dout_d = a_din;
            b_dout_d = b_din;
            rem_d    = rem_q - CW'(1);
        end

        // Sign-extended add; the accumulator wraps modulo 2^AW.
        if (prod_vld_q) begin
            acc_d = acc_q + AW'(prod_q);
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d   = mac_num;
                    acc_d   = '0;
                    state_d = (mac_num == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (fire && (rem_q == CW'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!prod_vld_q && !fwd_vld_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (acc_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            acc_q      <= '0;
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            fwd_vld_q  <= 1'b0;
            a_dout_q   <= '0;
            b_dout_q   <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            acc_q      <= acc_d;
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
            fwd_vld_q  <= fwd_vld_d;
            a_dout_q   <= a_dout_d;
            b_dout_q   <= b_dout_d;
        end
    end

    assign a_re    = fire;
    assign b_re    = fire;
    assign a_we    = fwd_vld_q;
    assign b_we    = fwd_vld_q;
    assign a_dout  = a_dout_q;
    assign b_dout  = b_dout_q;
    assign busy    = (state_q != IDLE);
    assign acc_vld = (state_q == DONE);
    assign acc     = acc_q;

endmodule

// File: tb/tb_systolic_pe.sv
// Self-checking bench for systolic_pe: a cycle-level behavioural model checks every
// output each cycle, directed scenarios pin literal results, then random traffic runs.
module tb_systolic_pe;
    localparam int DW = 16;
    localparam int AW = 40;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst, start, is, a_rv, b_rv, a_ff, b_ff, acc_rdy;
    logic [CW-1:0] mac_num;
    logic [DW-1:0] a_din, b_din, a_dout, b_dout;
    logic          a_re, b_re, a_we, b_we, busy, acc_vld;
    logic [AW-1:0] acc;

    always #5 clk = ~clk;

    systolic_pe #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .mac_num(mac_num), .is(is),
        .a_rv(a_rv), .b_rv(b_rv), .a_din(a_din), .b_din(b_din),
        .a_re(a_re), .b_re(b_re), .a_ff(a_ff), .b_ff(b_ff),
        .a_we(a_we), .b_we(b_we), .a_dout(a_dout), .b_dout(b_dout),
        .busy(busy), .acc_vld(acc_vld), .acc_rdy(acc_rdy), .acc(acc)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] exp_of(input longint v);
        logic [AW-1:0] t;
        t = AW'(v);
        return 64'(t);
    endfunction

    // Source FIFOs modelled as queues; the head is presented while the gate allows it.
    logic [DW-1:0] a_src[$];
    logic [DW-1:0] b_src[$];
    bit            a_en = 1'b1, b_en = 1'b1;
    longint        ref_acc;

    function automatic void drive();
        a_rv  = a_en && (a_src.size() > 0);
        b_rv  = b_en && (b_src.size() > 0);
        a_din = (a_src.size() > 0) ? a_src[0] : '0;
        b_din = (b_src.size() > 0) ? b_src[0] : '0;
    endfunction

    task automatic push(input int av, input int bv);
        a_src.push_back(DW'(av));
        b_src.push_back(DW'(bv));
        ref_acc += longint'(av) * longint'(bv);
    endtask

    // Behavioural model: a job is a count K, the products of the first K popped pairs,
    // and a result due three cycles after the last pop (one cycle after start for K=0).
    bit            m_on = 1'b0, m_active = 1'b0, m_we = 1'b0;
    int            m_k = 0, m_pops = 0, m_vld_at = -1, m_cyc = 0;
    logic [AW-1:0] m_sum = '0;
    logic [DW-1:0] m_ad = '0, m_bd = '0;
    int            n_fire = 0, n_we_a = 0, n_we_b = 0;

    always @(negedge clk) begin : compare
        bit ef, ev;
        ef = m_active && (m_pops < m_k) && a_rv && b_rv && !a_ff && !b_ff && !is && !rst;
        ev = m_active && (m_vld_at >= 0) && (m_cyc >= m_vld_at);
        if (m_on) begin
            check("a_re", 64'(a_re), 64'(ef));
            check("b_re", 64'(b_re), 64'(ef));
            check("busy", 64'(busy), 64'(m_active));
            check("acc_vld", 64'(acc_vld), 64'(ev));
            check("a_we", 64'(a_we), 64'(m_we));
            check("b_we", 64'(b_we), 64'(m_we));
            check("a_dout", 64'(a_dout), 64'(m_ad));
            check("b_dout", 64'(b_dout), 64'(m_bd));
            if (ev) check("acc", 64'(acc), 64'(m_sum));
        end
        if (a_re) n_fire++;
        if (a_we) n_we_a++;
        if (b_we) n_we_b++;
        if (rst) begin
            m_on = 1'b1; m_active = 1'b0; m_we = 1'b0;
            m_ad = '0; m_bd = '0; m_sum = '0; m_vld_at = -1;
        end else begin
            m_we = ef;
            if (ef) begin
                m_ad = a_din;
                m_bd = b_din;
                m_sum = m_sum + AW'(longint'($signed(a_din)) * longint'($signed(b_din)));
                m_pops++;
                if (m_pops == m_k) m_vld_at = m_cyc + 3;
            end
            if (!m_active && start) begin
                m_active = 1'b1;
                m_k      = int'(mac_num);
                m_pops   = 0;
                m_sum    = '0;
                m_vld_at = (mac_num == '0) ? m_cyc + 1 : -1;
            end else if (ev && acc_rdy) begin
                m_active = 1'b0;
            end
        end
        m_cyc++;
    end

    logic          s_vld, s_busy;
    logic [AW-1:0] s_acc;

    task automatic step();
        bit pa, pb;
        @(negedge clk);
        pa = a_re; pb = b_re;
        s_vld = acc_vld; s_acc = acc; s_busy = busy;
        @(posedge clk);
        #1;
        if (pa && a_src.size() > 0) void'(a_src.pop_front());
        if (pb && b_src.size() > 0) void'(b_src.pop_front());
        drive();
    endtask

    task automatic begin_dot(input int k);
        mac_num = CW'(k);
        start   = 1'b1;
        drive();
        step();
        start   = 1'b0;
    endtask

    task automatic wait_vld(input string name, input int budget);
        int n = 0;
        s_vld = 1'b0;
        while (!s_vld && n < budget) begin
            step();
            n++;
        end
        check({name, "_vld_timeout"}, 64'(s_vld), 64'd1);
    endtask

    task automatic finish_dot();
        acc_rdy = 1'b1;
        step();
        acc_rdy = 1'b0;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int f0, w0, wb0, n;
        rst = 1'b1; start = 1'b0; mac_num = '0; is = 1'b0;
        a_ff = 1'b0; b_ff = 1'b0; acc_rdy = 1'b0; ref_acc = 0;
        drive();
        repeat (2) step();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_acc_vld", 64'(acc_vld), 64'd0);
        check("rst_acc", 64'(acc), 64'd0);
        check("rst_we", 64'({a_we, b_we}), 64'd0);
        check("rst_re", 64'({a_re, b_re}), 64'd0);
        check("rst_dout", 64'({a_dout, b_dout}), 64'd0);
        rst = 1'b0;
        step();

        // Basic dot product: 1*5 + 2*6 + 3*7 + 4*8 = 70.
        ref_acc = 0;
        for (int i = 0; i < 4; i++) push(i + 1, i + 5);
        w0 = n_we_a; wb0 = n_we_b;
        begin_dot(4);
        wait_vld("basic", 50);
        check("basic_acc", 64'(s_acc), 64'd70);
        check("basic_fwd_a", 64'(n_we_a - w0), 64'd4);
        check("basic_fwd_b", 64'(n_we_b - wb0), 64'd4);
        finish_dot();

        // Most negative operands: 2 * 2^30 = 2^31, no overflow at AW=40.
        ref_acc = 0;
        repeat (2) push(-32768, -32768);
        begin_dot(2);
        wait_vld("signed", 50);
        check("signed_acc", 64'(s_acc), 64'h8000_0000);
        finish_dot();

        // Wraparound: after 512 products the sum sits at 2^39; 1030 * 2^30 mod 2^40 = 6 * 2^30.
        ref_acc = 0;
        repeat (1030) push(-32768, -32768);
        begin_dot(1030);
        wait_vld("wrap", 1200);
        check("wrap_acc", 64'(s_acc), 64'h1_8000_0000);
        check("wrap_ref", 64'(s_acc), exp_of(ref_acc));
        finish_dot();

        // Backpressure: 3*7 - 4*2 - 5*6 = -17, east FIFO full for 5 cycles after first fire.
        ref_acc = 0;
        push(3, 7); push(-4, 2); push(5, -6);
        w0 = n_we_a; wb0 = n_we_b;
        begin_dot(3);
        f0 = n_fire;
        step();
        a_ff = 1'b1;
        drive();
        repeat (5) step();
        check("bp_one_fire", 64'(n_fire - f0), 64'd1);
        a_ff = 1'b0;
        drive();
        wait_vld("bp", 50);
        check("bp_acc", 64'(s_acc), 64'hFF_FFFF_FFEF);
        check("bp_fwd_a", 64'(n_we_a - w0), 64'd3);
        check("bp_fwd_b", 64'(n_we_b - wb0), 64'd3);
        finish_dot();

        // Starvation then stall mid-run.
        ref_acc = 0;
        for (int i = 0; i < 4; i++) push(int'($urandom_range(0, 65535)) - 32768,
                                         int'($urandom_range(0, 65535)) - 32768);
        begin_dot(4);
        step();
        f0 = n_fire;
        b_en = 1'b0;
        drive();
        repeat (4) step();
        b_en = 1'b1; is = 1'b1;
        drive();
        repeat (3) step();
        check("stall_no_fire", 64'(n_fire - f0), 64'd0);
        check("stall_no_single_pop", 64'(a_src.size()), 64'd3);
        check("stall_busy", 64'(busy), 64'd1);
        is = 1'b0;
        drive();
        wait_vld("stall", 50);
        check("stall_acc", 64'(s_acc), exp_of(ref_acc));
        check("stall_fires", 64'(n_fire - f0), 64'd3);
        finish_dot();

        // K=0, held result and ignored starts.
        ref_acc = 0;
        push(9, 9); push(9, 9);
        f0 = n_fire;
        begin_dot(0);
        check("k0_vld", 64'(acc_vld), 64'd1);
        check("k0_acc", 64'(acc), 64'd0);
        for (int i = 0; i < 10; i++) begin
            start = 1'(i % 2); mac_num = CW'(5);
            step();
            check("k0_hold_vld", 64'(s_vld), 64'd1);
            check("k0_hold_acc", 64'(s_acc), 64'd0);
        end
        start = 1'b1;
        acc_rdy = 1'b1;
        step();
        start = 1'b0; acc_rdy = 1'b0;
        check("k0_return_idle", 64'(busy), 64'd0);
        check("k0_no_pop", 64'(n_fire - f0), 64'd0);
        a_src.delete(); b_src.delete();
        drive();
        step();

        // Reset after 2 of 4 fires, then a single-product job: -123 * 456 = -56088.
        ref_acc = 0;
        for (int i = 0; i < 4; i++) push(i + 10, i + 20);
        begin_dot(4);
        f0 = n_fire;
        n = 0;
        while ((n_fire - f0) < 2 && n < 20) begin
            step();
            n++;
        end
        check("rr_two_fires", 64'(n_fire - f0), 64'd2);
        rst = 1'b1;
        step();
        check("rr_busy", 64'(busy), 64'd0);
        check("rr_acc_vld", 64'(acc_vld), 64'd0);
        check("rr_acc", 64'(acc), 64'd0);
        check("rr_we", 64'({a_we, b_we}), 64'd0);
        check("rr_re", 64'({a_re, b_re}), 64'd0);
        check("rr_dout", 64'({a_dout, b_dout}), 64'd0);
        check("rr_no_pop", 64'(n_fire - f0), 64'd2);
        rst = 1'b0;
        a_src.delete(); b_src.delete();
        ref_acc = 0;
        push(-123, 456);
        begin_dot(1);
        wait_vld("rr_k1", 50);
        check("rr_k1_acc", 64'(s_acc), exp_of(-64'sd56088));
        finish_dot();

        // Random jobs under random starvation, backpressure, stalls and stray starts.
        for (int t = 0; t < 25; t++) begin
            int k;
            k = int'($urandom_range(0, 10));
            ref_acc = 0;
            for (int i = 0; i < k; i++) push(int'($urandom_range(0, 65535)) - 32768,
                                             int'($urandom_range(0, 65535)) - 32768);
            begin_dot(k);
            n = 0;
            s_vld = 1'b0;
            while (!s_vld && n < 300) begin
                a_en  = ($urandom_range(0, 9) < 8);
                b_en  = ($urandom_range(0, 9) < 8);
                a_ff  = ($urandom_range(0, 9) < 2);
                b_ff  = ($urandom_range(0, 9) < 2);
                is    = ($urandom_range(0, 9) == 0);
                start = ($urandom_range(0, 7) == 0);
                mac_num = CW'($urandom_range(0, 5));
                drive();
                step();
                n++;
            end
            check("rnd_vld_timeout", 64'(s_vld), 64'd1);
            check("rnd_acc", 64'(s_acc), exp_of(ref_acc));
            a_en = 1'b1; b_en = 1'b1; a_ff = 1'b0; b_ff = 1'b0; is = 1'b0; start = 1'b0;
            drive();
            repeat ($urandom_range(0, 3)) step();
            finish_dot();
        end

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/systolic_pe.md
SYSTOLIC_PE -- requirements
Module: systolic_pe

Interface
REQ-001 SHALL have parameter DW, default 16, meaning the operand width (signed two's complement).
REQ-002 SHALL have parameter AW, default 40, meaning the accumulator width.
REQ-003 SHALL have parameter CW, default 16, meaning the MAC-count width.
REQ-004 SHALL have port clk, input, 1, the single clock; every flop samples on its rising edge.
REQ-005 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, a one-cycle request to begin a dot product.
REQ-007 SHALL have port mac_num, input, CW, the number of MACs K, sampled on an accepted start.
REQ-008 SHALL have port is, input, 1, a stall: when high, no operand pop and no forward push.
REQ-009 SHALL have ports a_rv / b_rv, input, 1 each, meaning the west / north input FIFO holds data.
REQ-010 SHALL have ports a_din / b_din, input, DW each, meaning the west / north FIFO head data (valid while rv).
REQ-011 SHALL have ports a_re / b_re, output, 1 each, the pop strobe to the west / north FIFO.
REQ-012 SHALL have ports a_ff / b_ff, input, 1 each, the full flag of the east / south output FIFO.
REQ-013 SHALL have ports a_we / b_we, output, 1 each, the write strobe to the east / south FIFO.
REQ-014 SHALL have ports a_dout / b_dout, output, DW each, the forwarded operand to the east / south.
REQ-015 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-016 SHALL have port acc_vld, output, 1, the result-valid signal.
REQ-017 SHALL have port acc_rdy, input, 1, the result-consumer ready signal.
REQ-018 SHALL have port acc, output, AW, the accumulated result.

Function
REQ-019 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-020 SHALL accept start only in IDLE, latching mac_num into the remaining-count register and clearing the accumulator to 0.
- If mac_num is nonzero, the next state SHALL be RUN.
- If mac_num is 0, the next state SHALL be DONE.
REQ-021 SHALL ignore start in RUN, DRAIN and DONE.
REQ-022 SHALL define fire = RUN & a_rv & b_rv & ~a_ff & ~b_ff & ~is & (remaining != 0).
REQ-023 SHALL drive a_re = b_re = fire combinationally, so both operands pop in the same cycle; neither SHALL pop alone.
REQ-024 SHALL register a_din/b_din into a_dout/b_dout on fire, and drive a_we = b_we = 1 in the following cycle only; a_dout/b_dout SHALL otherwise hold.
REQ-025 SHALL register the full-precision signed product a_din*b_din (2*DW bits) on fire (stage 1), with a valid bit.
REQ-026 SHALL, one cycle later (stage 2), add the sign-extended product to acc, with wraparound modulo 2^AW and no saturation.
REQ-027 SHALL decrement the remaining count by 1 on each fire.
- When fire makes it reach 0, the next state SHALL be DRAIN.
REQ-028 SHALL stay in DRAIN until both pipeline valid bits are 0, then go to DONE.
- Total from last fire to acc_vld SHALL be 3 cycles.
REQ-029 SHALL hold acc_vld high in DONE; acc SHALL be stable while acc_vld is high.
REQ-030 SHALL return to IDLE on acc_vld & acc_rdy.
- A start in the return cycle SHALL be ignored.
REQ-031 SHALL, while is is high, freeze the remaining count and state and suppress fire.
- Pipeline stages already loaded SHALL still complete.
REQ-032 SHALL rely on a_ff/b_ff going high only at 3 entries, so one in-flight write after ff rises is absorbed; the PE SHALL NOT fire while either ff is high.
REQ-033 SHALL, when a_rv & b_rv is false in RUN, wait indefinitely with no timeout and no partial pop.

Reset
REQ-034 SHALL, when rst is high at a clock edge, set state=IDLE, acc=0, remaining=0, pipeline valids=0, a_dout=b_dout=0, a_we=b_we=0 and acc_vld=0.
REQ-035 SHALL abort an in-progress dot product on rst asserted mid-operation, with no further pops or pushes and the partial acc discarded.
REQ-036 SHALL keep outputs a_re/b_re at 0 during reset.

Verification
REQ-037 SHALL verify the basic dot product: start, K=4; a={1,2,3,4}, b={5,6,7,8}, FIFOs always ready → acc_vld 3 cycles after the 4th fire with acc=70; 4 a_we/b_we pulses forward identical data.
REQ-038 SHALL verify signed and wrap behaviour: K=2, a={-32768,-32768}, b={-32768,-32768} → acc=2^31 (no overflow at AW=40); a separate case with preset near 2^39 wraps mod 2^40.
REQ-039 SHALL verify backpressure: K=3, a_ff high for 5 cycles after the first fire → exactly 1 fire before the stall, no a_re/b_re while ff is high, final acc correct, no lost or duplicated forward.
REQ-040 SHALL verify starvation and stall: b_rv low for 4 cycles, then is high for 3 cycles mid-run → no single-sided pop, remaining frozen, result matches the reference sum.
REQ-041 SHALL verify K=0 and result handshake: start with mac_num=0 → DONE next cycle with acc=0; acc_rdy held low for 10 cycles → acc_vld and acc stable; start is ignored until return to IDLE.
REQ-042 SHALL verify reset mid-run: rst pulsed after 2 of 4 fires → all outputs at reset values next cycle; a new start with K=1 then yields the correct single product.
